// File: rtl/wgt_pkg.sv
// Shared types and defaults for the weight fetch path (also used by wgt_addr_controller).
package wgt_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StFull = 2'd2
  } wgt_state_e;

  localparam int unsigned KernelSizeDef = 3;
  localparam int unsigned NoChannelDef  = 3;
  localparam int unsigned AddrWidthDef  = 11;
  localparam int unsigned DataWidthDef  = 8;

  function automatic int unsigned calc_no_wgt(int unsigned k, int unsigned c);
    return k * k * c;
  endfunction

  localparam int unsigned NoWgtDef    = calc_no_wgt(KernelSizeDef, NoChannelDef);
  localparam int unsigned CntWidthDef = $clog2(NoWgtDef + 1);

endpackage

// File: rtl/wgt_fetch_unit_if.sv
// Address-in / SRAM / weight-vector bundle of wgt_fetch_unit.
// addr_err exists only when WGT_ADDR_CHECK_EN is defined.
interface wgt_fetch_unit_if
  import wgt_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned NO_WGT     = NoWgtDef
);
  logic                         addr_valid;
  logic [ADDR_WIDTH-1:0]        wgt_addr;
  logic                         mem_rd_en;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_rdata;
  logic [NO_WGT*DATA_WIDTH-1:0] wgt_vec;
  logic                         wgt_valid;
  logic                         wgt_ack;
  logic                         overflow;
`ifdef WGT_ADDR_CHECK_EN
  logic                         addr_err;

  modport slave (
    input  addr_valid, wgt_addr, mem_rdata, wgt_ack,
    output mem_rd_en, mem_addr, wgt_vec, wgt_valid, overflow, addr_err
  );
  modport master (
    output addr_valid, wgt_addr, mem_rdata, wgt_ack,
    input  mem_rd_en, mem_addr, wgt_vec, wgt_valid, overflow, addr_err
  );
`else
  modport slave (
    input  addr_valid, wgt_addr, mem_rdata, wgt_ack,
    output mem_rd_en, mem_addr, wgt_vec, wgt_valid, overflow
  );
  modport master (
    output addr_valid, wgt_addr, mem_rdata, wgt_ack,
    input  mem_rd_en, mem_addr, wgt_vec, wgt_valid, overflow
  );
`endif
endinterface

// File: rtl/wgt_vec_reg.sv
// Indexed-write weight register file with a flat packed output (element i at i*DataWidth).
module wgt_vec_reg #(
  parameter int unsigned NoWgt     = 27,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned IdxWidth  = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [IdxWidth-1:0]        idx_i,
  input  logic [DataWidth-1:0]       wdata_i,
  output logic [NoWgt*DataWidth-1:0] vec_o
);

  for (genvar i = 0; i < NoWgt; i++) begin : g_elem
    logic [DataWidth-1:0] elem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        elem_q <= '0;
      end else if (we_i && (idx_i == IdxWidth'(i))) begin
        elem_q <= wdata_i;
      end
    end

    assign vec_o[i*DataWidth +: DataWidth] = elem_q;
  end

endmodule

// File: rtl/wgt_fetch_unit.sv
// Turns a weight-address stream into SRAM reads and packs the returned words into one vector.
// Optional WGT_ADDR_CHECK_EN adds a sticky addr_err for non-consecutive addresses.
module wgt_fetch_unit
  import wgt_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = KernelSizeDef,
  parameter int unsigned NO_CHANNEL  = NoChannelDef,
  parameter int unsigned ADDR_WIDTH  = AddrWidthDef,
  parameter int unsigned DATA_WIDTH  = DataWidthDef
) (
  input logic             clk,
  input logic             rst_n,
  wgt_fetch_unit_if.slave bus
);

  localparam int unsigned NO_WGT    = calc_no_wgt(KERNEL_SIZE, NO_CHANNEL);
  localparam int unsigned CNT_WIDTH = $clog2(NO_WGT + 1);

  wgt_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0] rcv_cnt_q, rcv_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 overflow_q, overflow_d;
  logic                 accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      rd_pend_q   <= rd_pend_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    accept      = bus.addr_valid && (state_q != StFull) && (issue_cnt_q < CNT_WIDTH'(NO_WGT));
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    rd_pend_d   = accept;
    overflow_d  = overflow_q;

    if (accept) issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
    if (rd_pend_q) rcv_cnt_d = rcv_cnt_q + CNT_WIDTH'(1);
    if (bus.addr_valid && !accept) overflow_d = 1'b1;

    unique case (state_q)
      StIdle: if (accept) state_d = StFill;
      StFill: begin
        // Last word lands this edge, so FULL is visible the cycle after it is stored.
        if (rd_pend_q && (rcv_cnt_q == CNT_WIDTH'(NO_WGT - 1))) begin
          state_d     = StFull;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
        end
      end
      StFull: if (bus.wgt_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_rd_en = accept;
  assign bus.mem_addr  = bus.wgt_addr;
  assign bus.wgt_valid = (state_q == StFull);
  assign bus.overflow  = overflow_q;

  wgt_vec_reg #(
    .NoWgt    (NO_WGT),
    .DataWidth(DATA_WIDTH),
    .IdxWidth (CNT_WIDTH)
  ) u_vec_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (rd_pend_q),
    .idx_i  (rcv_cnt_q),
    .wdata_i(bus.mem_rdata),
    .vec_o  (bus.wgt_vec)
  );

`ifdef WGT_ADDR_CHECK_EN
  logic [ADDR_WIDTH-1:0] prev_addr_q;
  logic                  addr_err_q;

  // issue_cnt_q == 0 marks the first address of a vector, which has no predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_addr_q <= '0;
      addr_err_q  <= 1'b0;
    end else if (accept) begin
      prev_addr_q <= bus.wgt_addr;
      if ((issue_cnt_q != '0) && (bus.wgt_addr != prev_addr_q + ADDR_WIDTH'(1))) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign bus.addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_wgt_fetch_unit.sv
// Bench for wgt_fetch_unit: directed scenario table, reset/addr-check sequences, random model run.
module tb_wgt_fetch_unit;
  localparam int NW = 27;
  localparam int VW = NW * 8;

  typedef struct {
    int       n_addr;
    int       gap_a;
    int       gap_b;
    int       gap_len;
    int       hold;
    int       exp_cycle;
    bit       exp_ovf;
    bit [7:0] key;
  } scen_t;

  logic clk, rst_n;
  wgt_fetch_unit_if bus ();

  wgt_fetch_unit u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [0:2047];
  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit [7:0] key);
    for (int a = 0; a < 2048; a++) mem[a] = (8'(a) + 8'h10) ^ key;
  endtask

  function automatic logic [VW-1:0] seq_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*8 +: 8] = mem[i];
    return v;
  endfunction

  task automatic run_scen(input scen_t s, input int idx);
    int addr_i = 0;
    int gap = 0;
    int vcyc = -1;
    logic [VW-1:0] exp_v;
    exp_v = seq_vec();
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (vcyc >= 0 && addr_i >= s.n_addr) break;
      if (gap > 0) begin
        bus.addr_valid = 1'b0;
        gap--;
      end else if (addr_i < s.n_addr) begin
        bus.addr_valid = 1'b1;
        bus.wgt_addr   = 11'(addr_i);
        if (addr_i == s.gap_a || addr_i == s.gap_b) gap = s.gap_len;
        addr_i++;
      end else begin
        bus.addr_valid = 1'b0;
      end
      #1;
      if (bus.wgt_valid && vcyc < 0) vcyc = cyc;
      tick();
    end
    bus.addr_valid = 1'b0;
    check($sformatf("scen%0d valid_cycle", idx), VW'(vcyc), VW'(s.exp_cycle));
    check($sformatf("scen%0d vec", idx), bus.wgt_vec, exp_v);
    check($sformatf("scen%0d overflow", idx), VW'(bus.overflow), VW'(s.exp_ovf));
    for (int h = 0; h < s.hold; h++) begin
      check($sformatf("scen%0d hold_valid", idx), VW'(bus.wgt_valid), VW'(1));
      check($sformatf("scen%0d hold_vec", idx), bus.wgt_vec, exp_v);
      tick();
    end
    bus.wgt_ack = 1'b1;
    tick();
    bus.wgt_ack = 1'b0;
    check($sformatf("scen%0d valid_after_ack", idx), VW'(bus.wgt_valid), VW'(0));
    check($sformatf("scen%0d vec_after_ack", idx), bus.wgt_vec, exp_v);
    tick();
  endtask

  scen_t tbl [5];

  initial begin
    bit m_hold, m_ovf, was_hold, exp_rd;
    int m_cd;
    logic [10:0] m_q [$];
    logic [VW-1:0] m_vec;

    tbl[0] = '{n_addr: 27, gap_a: -1, gap_b: -1, gap_len: 0, hold: 20, exp_cycle: 28, exp_ovf: 0, key: 8'h00};
    tbl[1] = '{n_addr: 27, gap_a: 4,  gap_b: 17, gap_len: 5, hold: 0,  exp_cycle: 38, exp_ovf: 0, key: 8'h00};
    tbl[2] = '{n_addr: 30, gap_a: -1, gap_b: -1, gap_len: 0, hold: 0,  exp_cycle: 28, exp_ovf: 1, key: 8'h33};
    tbl[3] = '{n_addr: 27, gap_a: -1, gap_b: -1, gap_len: 0, hold: 0,  exp_cycle: 28, exp_ovf: 1, key: 8'h77};
    tbl[4] = '{n_addr: 27, gap_a: -1, gap_b: -1, gap_len: 0, hold: 0,  exp_cycle: 28, exp_ovf: 0, key: 8'hC3};

    rst_n = 1'b0;
    bus.addr_valid = 1'b0;
    bus.wgt_addr   = '0;
    bus.wgt_ack    = 1'b0;
    fill_mem(8'h00);
    #3;
    check("reset wgt_valid", VW'(bus.wgt_valid), VW'(0));
    check("reset overflow", VW'(bus.overflow), VW'(0));
    check("reset wgt_vec", bus.wgt_vec, '0);
    check("reset mem_rd_en", VW'(bus.mem_rd_en), VW'(0));
`ifdef WGT_ADDR_CHECK_EN
    check("reset addr_err", VW'(bus.addr_err), VW'(0));
`endif
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      fill_mem(tbl[i].key);
      run_scen(tbl[i], i);
    end

    // Reset twelve words into a fill; nothing stale may survive into the next vector.
    fill_mem(8'h5A);
    for (int k = 0; k < 12; k++) begin
      bus.addr_valid = 1'b1;
      bus.wgt_addr   = 11'(k);
      tick();
    end
    bus.addr_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midfill_rst wgt_vec", bus.wgt_vec, '0);
    check("midfill_rst wgt_valid", VW'(bus.wgt_valid), VW'(0));
    check("midfill_rst overflow", VW'(bus.overflow), VW'(0));
    #3 rst_n = 1'b1;
    tick();
    fill_mem(tbl[4].key);
    run_scen(tbl[4], 4);

`ifdef WGT_ADDR_CHECK_EN
    fill_mem(8'h00);
    begin
      int vc = -1;
      logic [VW-1:0] ev;
      for (int k = 0; k < NW; k++) ev[k*8 +: 8] = mem[(k < 10) ? k : k + 1];
      for (int cyc = 0; cyc < 40; cyc++) begin
        bus.addr_valid = (cyc < NW);
        bus.wgt_addr   = 11'((cyc < 10) ? cyc : cyc + 1);
        #1;
        if (cyc == 10) check("addr_err before", VW'(bus.addr_err), VW'(0));
        if (cyc == 11) check("addr_err after", VW'(bus.addr_err), VW'(1));
        if (bus.wgt_valid && vc < 0) vc = cyc;
        tick();
      end
      bus.addr_valid = 1'b0;
      check("addr_err valid_cycle", VW'(vc), VW'(28));
      check("addr_err vec", bus.wgt_vec, ev);
      bus.wgt_ack = 1'b1;
      tick();
      bus.wgt_ack = 1'b0;
      tick();
    end
`endif

    // Random traffic against a queue-based model of accepted addresses.
    for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    m_hold = 0;
    m_ovf  = 0;
    m_cd   = 0;
    m_vec  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.addr_valid = ($urandom_range(0, 9) < 8);
      bus.wgt_addr   = 11'($urandom_range(0, 2047));
      bus.wgt_ack    = ($urandom_range(0, 3) == 0);
      #1;
      exp_rd = bus.addr_valid && !m_hold && (m_q.size() < NW);
      check("rnd wgt_valid", VW'(bus.wgt_valid), VW'(m_hold));
      check("rnd mem_rd_en", VW'(bus.mem_rd_en), VW'(exp_rd));
      check("rnd overflow", VW'(bus.overflow), VW'(m_ovf));
      if (exp_rd) check("rnd mem_addr", VW'(bus.mem_addr), VW'(bus.wgt_addr));
      if (m_hold) check("rnd wgt_vec", bus.wgt_vec, m_vec);
      was_hold = m_hold;
      if (bus.addr_valid && !exp_rd) m_ovf = 1;
      if (was_hold && bus.wgt_ack) m_hold = 0;
      if (m_cd == 1) begin
        m_cd   = 0;
        m_hold = 1;
        for (int i = 0; i < NW; i++) m_vec[i*8 +: 8] = mem[m_q[i]];
        m_q.delete();
      end
      if (exp_rd) begin
        m_q.push_back(bus.wgt_addr);
        if (m_q.size() == NW) m_cd = 1;
      end
      tick();
    end
    bus.addr_valid = 1'b0;
    bus.wgt_ack    = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wgt_fetch_unit.md
Name: wgt_fetch_unit

Overview:
- Consumer end of the weight-address stream produced by wgt_addr_controller.
- Each valid wgt_addr becomes a read of the weight SRAM.
- Returned data words are packed into one KERNEL_SIZE*KERNEL_SIZE*NO_CHANNEL weight vector.
- The full vector is held for the systolic array until it is acknowledged. No backpressure exists toward the address generator, so excess addresses are dropped and flagged.

Parameters:
KERNEL_SIZE, 3, kernel height/width
NO_CHANNEL, 3, input channels per kernel
ADDR_WIDTH, 11, weight SRAM address width
DATA_WIDTH, 8, weight word width
NO_WGT (localparam), KERNEL_SIZE*KERNEL_SIZE*NO_CHANNEL = 27, words per vector
CNT_WIDTH (localparam), $clog2(NO_WGT+1) = 5, counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
addr_valid  in  1  wgt_addr valid this cycle
wgt_addr  in  ADDR_WIDTH  weight SRAM address
mem_rd_en  out  1  SRAM read enable (combinational)
mem_addr  out  ADDR_WIDTH  SRAM read address (combinational)
mem_rdata  in  DATA_WIDTH  SRAM data, valid one cycle after mem_rd_en
wgt_vec  out  NO_WGT*DATA_WIDTH  packed weights; element i at [i*DATA_WIDTH +: DATA_WIDTH]
wgt_valid  out  1  wgt_vec complete and stable
wgt_ack  in  1  array consumed wgt_vec
overflow  out  1  sticky: an address was dropped

Behaviour:
- Reset (asynchronous, any state, including mid-fill): state=IDLE; issue_cnt=0; rcv_cnt=0; rd_pend=0; wgt_vec=0; wgt_valid=0; overflow=0. Any in-flight read is discarded.
- accept = addr_valid && state!=FULL && issue_cnt<NO_WGT.
- mem_rd_en = accept; mem_addr = wgt_addr. When accept=0, mem_addr still follows wgt_addr (don't-care).
- On accept: issue_cnt++ and rd_pend<=1. Otherwise rd_pend<=0.
- On rd_pend: wgt_vec element rcv_cnt <= mem_rdata, then rcv_cnt++. Element 0 is the first accepted address.
- Latency: address accepted in cycle t → stored at the end of cycle t+1. The last word stored at the end of cycle t → wgt_valid=1 from cycle t+1.
- FSM:
  - IDLE: first accept → FILL.
  - FILL: when rcv_cnt reaches NO_WGT → FULL, with wgt_valid=1 and issue_cnt=rcv_cnt=0.
  - FULL: wgt_vec frozen; wgt_valid held until wgt_ack. On wgt_ack → IDLE and wgt_valid<=0; wgt_vec keeps its value until overwritten.
- wgt_ack outside FULL is ignored.
- Dropped address:
  - addr_valid in FULL (including the ack cycle), or in FILL with issue_cnt==NO_WGT → no read issued, overflow<=1.
  - overflow clears only on reset.
- Gaps in addr_valid are allowed; the fill simply waits. There is no timeout.
- Back-to-back addresses sustain one word per cycle. A 27-address burst starting in cycle 0 gives wgt_valid=1 in cycle 28.

Optional Feature:
- Macro: WGT_ADDR_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0, sticky).
  - Set when an accepted address is not prev_accepted+1 within a vector.
  - The first address of each vector is unchecked.
  - Adds one ADDR_WIDTH register.
- Undefined: no port and no logic; behaviour otherwise identical.

Decomposition:
- Shared package wgt_pkg holds:
  - FSM state encoding: IDLE=2'd0, FILL=2'd1, FULL=2'd2.
  - NO_WGT and CNT_WIDTH derivation.
  - Defaults shared with wgt_addr_controller.
- One natural sub-module: wgt_vec_reg, the NO_WGT-entry indexed write register with packed output, driven by a write enable and index.
- Control FSM and counters stay in the top module.

Test Plan:
- Reset → all outputs 0. Then 27 back-to-back addresses 0..26, with the SRAM model returning data=addr+8'h10 → wgt_valid rises in cycle 28, wgt_vec element i == 8'h10+i, overflow=0.
- Hold wgt_ack=0 for 20 cycles after wgt_valid → vec stable, wgt_valid held. Pulse wgt_ack → wgt_valid=0 next cycle, state IDLE.
- Addresses 0..26 with addr_valid deasserted for 5 cycles after addresses 4 and 17 → wgt_valid 10 cycles later than the burst case, contents identical.
- 30 consecutive addr_valid with no ack → 27 reads issued, last 3 dropped, overflow=1. After ack, a new 27-address burst fills correctly; overflow stays 1.
- Assert rst_n=0 after 12 words of a fill → immediate clear. A following full burst produces a correct vector with no stale words.
- WGT_ADDR_CHECK_EN defined, address sequence 0..9,11..27 → addr_err=1 one cycle after 11 is accepted; the vector still completes.
